// File: rtl/jtag_types_pkg.sv
// ----------------------------------------------------------------------------
// jtag_types_pkg
// Shared JTAG debug types: DR field encodings, AHB access-port state and
// AHB-Lite constants.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package jtag_types_pkg;

  // Register select carried in the AP scan word
  typedef enum logic {
    REGSEL_ADDRESS = 1'b0,
    REGSEL_DATA    = 1'b1
  } regselect_t;

  // Transfer size, also the low two bits of HSIZE
  typedef enum logic [1:0] {
    HSIZE_BYTE     = 2'b00,
    HSIZE_HALFWORD = 2'b01,
    HSIZE_WORD     = 2'b10
  } hsize_t;

  // Direction bit of the AP scan word
  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } r_w_t;

  // AHB access-port sequencer states
  typedef enum logic [1:0] {
    AP_IDLE    = 2'b00,
    AP_ADDR_PH = 2'b01,
    AP_DATA_PH = 2'b10,
    AP_RESP    = 2'b11
  } ap_state_t;

  // Only single transfers are issued, so IDLE and NONSEQ suffice
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Address stride for a given transfer size: 1, 2 or 4 bytes
  function automatic logic [31:0] size_incr(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_ap_lane_mux.sv
// ----------------------------------------------------------------------------
// jtag_ap_lane_mux
// Combinational byte-lane helper for the AHB access port: write-data lane
// replication, read-data lane extraction and alignment check.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtag_ap_lane_mux
  import jtag_types_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [31:0] wr_data,
  output logic [31:0] wr_lanes,
  input  logic [1:0]  chk_size,
  input  logic [1:0]  chk_addr,
  output logic        misaligned,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_addr,
  input  logic [31:0] rd_bus,
  output logic [31:0] rd_data
);

  // Replicate the narrow write value onto every lane so any slave lane sees it
  always_comb begin
    wr_lanes = wr_data;
    case (wr_size)
      HSIZE_BYTE:     wr_lanes = {4{wr_data[7:0]}};
      HSIZE_HALFWORD: wr_lanes = {2{wr_data[15:0]}};
      default:        wr_lanes = wr_data;
    endcase
  end

  // Illegal size or unaligned address makes the request unserviceable
  always_comb begin
    misaligned = 1'b1;
    case (chk_size)
      HSIZE_BYTE:     misaligned = 1'b0;
      HSIZE_HALFWORD: misaligned = chk_addr[0];
      HSIZE_WORD:     misaligned = |chk_addr;
      default:        misaligned = 1'b1;
    endcase
  end

  // Pick the addressed lane out of HRDATA and zero-extend it
  always_comb begin
    rd_data = 32'd0;
    case (rd_size)
      HSIZE_BYTE: begin
        case (rd_addr)
          2'b00:   rd_data = {24'd0, rd_bus[7:0]};
          2'b01:   rd_data = {24'd0, rd_bus[15:8]};
          2'b10:   rd_data = {24'd0, rd_bus[23:16]};
          default: rd_data = {24'd0, rd_bus[31:24]};
        endcase
      end
      HSIZE_HALFWORD: rd_data = rd_addr[1] ? {16'd0, rd_bus[31:16]} : {16'd0, rd_bus[15:0]};
      HSIZE_WORD:     rd_data = rd_bus;
      default:        rd_data = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/jtag_ahb_ap.sv
// ----------------------------------------------------------------------------
// jtag_ahb_ap
// AHB-Lite single-transfer master driven by JTAG AP requests. Loads the AP
// address register or performs one read/write, returning data and status.
// Optional hung-slave timeout: define JTAG_AP_TIMEOUT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module jtag_ahb_ap
  import jtag_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_data,
  input  logic        req_regselect,
  input  logic [1:0]  req_size,
  input  logic        req_addrinc,
  input  logic        req_rw,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        sticky_err,
  input  logic        err_clr,
  output logic [31:0] cur_addr,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
`ifdef JTAG_AP_TIMEOUT_EN
  ,
  output logic        ap_timeout
`endif
);

  ap_state_t   state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [1:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        addrinc_q, addrinc_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;
  logic        sticky_q, sticky_d;
  logic        set_err;

  logic [31:0] req_lanes;
  logic        req_misaligned;
  logic [31:0] rd_lane;

`ifdef JTAG_AP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            set_to;
`endif

  // Requests are checked against the current AP address; reads use the
  // address/size latched for the bus transfer in flight.
  jtag_ap_lane_mux u_lane_mux (
    .wr_size    (req_size),
    .wr_data    (req_data),
    .wr_lanes   (req_lanes),
    .chk_size   (req_size),
    .chk_addr   (cur_addr_q[1:0]),
    .misaligned (req_misaligned),
    .rd_size    (hsize_q),
    .rd_addr    (haddr_q[1:0]),
    .rd_bus     (HRDATA),
    .rd_data    (rd_lane)
  );

  // Next-state and next-output computation for the transfer sequencer
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hwdata_d    = hwdata_q;
    addrinc_d   = addrinc_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    set_err     = 1'b0;

    case (state_q)
      AP_IDLE: begin
        if (req_valid) begin
          if (req_regselect == REGSEL_ADDRESS) begin
            // Address loads never touch the bus and ignore the sticky error
            cur_addr_d  = req_data;
            rsp_data_d  = 32'd0;
            rsp_error_d = 1'b0;
            state_d     = AP_RESP;
          end else if (req_misaligned || sticky_q) begin
            rsp_data_d  = 32'd0;
            rsp_error_d = 1'b1;
            set_err     = 1'b1;
            state_d     = AP_RESP;
          end else begin
            state_d   = AP_ADDR_PH;
            htrans_d  = HTRANS_NONSEQ;
            haddr_d   = cur_addr_q;
            hwrite_d  = req_rw;
            hsize_d   = req_size;
            addrinc_d = req_addrinc;
            if (req_rw == RW_WRITE) begin
              hwdata_d = req_lanes;
            end
          end
        end
      end
      AP_ADDR_PH: begin
        if (HREADY) begin
          state_d  = AP_DATA_PH;
          htrans_d = HTRANS_IDLE;
        end
      end
      AP_DATA_PH: begin
        // HREADY low with HRESP high is the first error cycle: just a wait
        if (HREADY) begin
          state_d = AP_RESP;
          if (HRESP) begin
            rsp_data_d  = 32'd0;
            rsp_error_d = 1'b1;
            set_err     = 1'b1;
          end else begin
            rsp_data_d  = hwrite_q ? 32'd0 : rd_lane;
            rsp_error_d = 1'b0;
            if (addrinc_q) begin
              cur_addr_d = cur_addr_q + size_incr(hsize_q);
            end
          end
        end
      end
      default: begin
        state_d = AP_IDLE;
      end
    endcase

`ifdef JTAG_AP_TIMEOUT_EN
    to_cnt_d = '0;
    set_to   = 1'b0;
    if ((state_q == AP_ADDR_PH || state_q == AP_DATA_PH) && !HREADY) begin
      if (to_cnt_q == TO_LAST) begin
        state_d     = AP_RESP;
        htrans_d    = HTRANS_IDLE;
        rsp_data_d  = 32'd0;
        rsp_error_d = 1'b1;
        set_err     = 1'b1;
        set_to      = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
    timeout_d = set_to ? 1'b1 : (err_clr ? 1'b0 : timeout_q);
`endif

    // A new error beats a simultaneous clear
    sticky_d = set_err ? 1'b1 : (err_clr ? 1'b0 : sticky_q);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= AP_IDLE;
      cur_addr_q  <= 32'd0;
      haddr_q     <= 32'd0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= 2'b00;
      hwdata_q    <= 32'd0;
      addrinc_q   <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_error_q <= 1'b0;
      sticky_q    <= 1'b0;
`ifdef JTAG_AP_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      haddr_q     <= haddr_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      addrinc_q   <= addrinc_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      sticky_q    <= sticky_d;
`ifdef JTAG_AP_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign req_ready  = (state_q == AP_IDLE);
  assign rsp_valid  = (state_q == AP_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_error  = rsp_error_q;
  assign sticky_err = sticky_q;
  assign cur_addr   = cur_addr_q;
  assign HADDR      = haddr_q;
  assign HTRANS     = htrans_q;
  assign HWRITE     = hwrite_q;
  assign HSIZE      = {1'b0, hsize_q};
  assign HBURST     = HBURST_SINGLE;
  assign HPROT      = HPROT_DEFAULT;
  assign HWDATA     = hwdata_q;
`ifdef JTAG_AP_TIMEOUT_EN
  assign ap_timeout = timeout_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtag_ahb_ap.sv
// ----------------------------------------------------------------------------
// tb_jtag_ahb_ap
// Directed self-checking bench for jtag_ahb_ap.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_jtag_ahb_ap;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid, req_ready;
  logic [31:0] req_data;
  logic        req_regselect;
  logic [1:0]  req_size;
  logic        req_addrinc, req_rw;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error, sticky_err, err_clr;
  logic [31:0] cur_addr, HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
`ifdef JTAG_AP_TIMEOUT_EN
  logic        ap_timeout;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  jtag_ahb_ap #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_regselect(req_regselect), .req_size(req_size),
    .req_addrinc(req_addrinc), .req_rw(req_rw),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .sticky_err(sticky_err), .err_clr(err_clr), .cur_addr(cur_addr),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
`ifdef JTAG_AP_TIMEOUT_EN
    , .ap_timeout(ap_timeout)
`endif
  );

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance
  task automatic send(input logic rs, input logic [31:0] d, input logic [1:0] sz,
                      input logic rw, input logic inc);
    req_valid = 1'b1; req_regselect = rs; req_data = d;
    req_size = sz; req_rw = rw; req_addrinc = inc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic load_addr(input logic [31:0] a);
    send(1'b0, a, 2'b00, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready); else n_pass++;
    n_chk++; if (HTRANS !== 2'b00) $display("FAIL rst_htrans got %b want 00", HTRANS); else n_pass++;
    n_chk++; if (cur_addr !== 32'h0) $display("FAIL rst_cur_addr got %h want 0", cur_addr); else n_pass++;
    n_chk++; if ({rsp_valid, rsp_error, sticky_err, HWRITE} !== 4'b0000)
      $display("FAIL rst_flags got %b want 0000", {rsp_valid, rsp_error, sticky_err, HWRITE}); else n_pass++;
    n_chk++; if ({HADDR, HWDATA, rsp_data} !== 96'h0) $display("FAIL rst_data got %h want 0", {HADDR, HWDATA, rsp_data}); else n_pass++;
    n_chk++; if ({HSIZE, HBURST, HPROT} !== {3'b000, 3'b000, 4'b0011})
      $display("FAIL rst_hctrl got %b want 0000000011", {HSIZE, HBURST, HPROT}); else n_pass++;
    nRST = 1'b1;
    step();
  endtask

  task automatic test_word_write();
    send(1'b0, 32'h2000_0000, 2'b00, 1'b0, 1'b0);
    n_chk++; if ({rsp_valid, rsp_error, req_ready} !== 3'b100)
      $display("FAIL addr_rsp got %b want 100", {rsp_valid, rsp_error, req_ready}); else n_pass++;
    n_chk++; if (cur_addr !== 32'h2000_0000) $display("FAIL addr_load got %h want 20000000", cur_addr); else n_pass++;
    step();
    n_chk++; if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL addr_done got %b want 01", {rsp_valid, req_ready}); else n_pass++;
    send(1'b1, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b1);
    n_chk++; if ({HTRANS, HWRITE, HSIZE} !== {2'b10, 1'b1, 3'b010})
      $display("FAIL ww_aphase got %b want 101010", {HTRANS, HWRITE, HSIZE}); else n_pass++;
    n_chk++; if (HADDR !== 32'h2000_0000) $display("FAIL ww_haddr got %h want 20000000", HADDR); else n_pass++;
    step();
    n_chk++; if (HTRANS !== 2'b00 || HWDATA !== 32'hDEAD_BEEF)
      $display("FAIL ww_dphase got %b/%h want 00/deadbeef", HTRANS, HWDATA); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL ww_early_rsp got %b want 0", rsp_valid); else n_pass++;
    step();
    n_chk++; if ({rsp_valid, rsp_error} !== 2'b10) $display("FAIL ww_rsp got %b want 10", {rsp_valid, rsp_error}); else n_pass++;
    n_chk++; if (cur_addr !== 32'h2000_0004) $display("FAIL ww_inc got %h want 20000004", cur_addr); else n_pass++;
    step();
  endtask

  task automatic test_reads();
    load_addr(32'h0000_0103);
    send(1'b1, 32'h0000_005A, 2'b00, 1'b1, 1'b0);
    step();
    n_chk++; if (HWDATA !== 32'h5A5A_5A5A) $display("FAIL bw_lanes got %h want 5a5a5a5a", HWDATA); else n_pass++;
    step(); step();
    HRDATA = 32'hAB00_0000;
    send(1'b1, 32'h0, 2'b00, 1'b0, 1'b0);
    n_chk++; if ({HTRANS, HWRITE, HSIZE} !== {2'b10, 1'b0, 3'b000})
      $display("FAIL br_aphase got %b want 100000", {HTRANS, HWRITE, HSIZE}); else n_pass++;
    step(); step();
    n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_00AB)
      $display("FAIL br_data got %b/%h want 1/000000ab", rsp_valid, rsp_data); else n_pass++;
    n_chk++; if (cur_addr !== 32'h0000_0103) $display("FAIL br_noinc got %h want 00000103", cur_addr); else n_pass++;
    step();
    load_addr(32'h0000_0102);
    HRDATA = 32'h1234_0000;
    send(1'b1, 32'h0, 2'b01, 1'b0, 1'b1);
    step(); step();
    n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_1234)
      $display("FAIL hr_data got %b/%h want 1/00001234", rsp_valid, rsp_data); else n_pass++;
    n_chk++; if (cur_addr !== 32'h0000_0104) $display("FAIL hr_inc got %h want 00000104", cur_addr); else n_pass++;
    step();
  endtask

  task automatic test_misalign();
    load_addr(32'h0000_0001);
    send(1'b1, 32'h1111_1111, 2'b10, 1'b1, 1'b0);
    n_chk++; if (HTRANS !== 2'b00) $display("FAIL mis_htrans got %b want 00", HTRANS); else n_pass++;
    n_chk++; if ({rsp_valid, rsp_error, sticky_err} !== 3'b111)
      $display("FAIL mis_rsp got %b want 111", {rsp_valid, rsp_error, sticky_err}); else n_pass++;
    step();
    send(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
    n_chk++; if ({rsp_valid, rsp_error, sticky_err} !== 3'b101)
      $display("FAIL mis_addr_ok got %b want 101", {rsp_valid, rsp_error, sticky_err}); else n_pass++;
    step();
    send(1'b1, 32'h2222_2222, 2'b10, 1'b1, 1'b0);
    n_chk++; if ({HTRANS, rsp_valid, rsp_error} !== 4'b0011)
      $display("FAIL sticky_rej got %b want 0011", {HTRANS, rsp_valid, rsp_error}); else n_pass++;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_chk++; if (sticky_err !== 1'b0) $display("FAIL err_clr got %b want 0", sticky_err); else n_pass++;
    send(1'b1, 32'h1122_3344, 2'b10, 1'b1, 1'b0);
    n_chk++; if (HTRANS !== 2'b10) $display("FAIL retry_htrans got %b want 10", HTRANS); else n_pass++;
    step(); step();
    n_chk++; if ({rsp_valid, rsp_error, sticky_err} !== 3'b100)
      $display("FAIL retry_rsp got %b want 100", {rsp_valid, rsp_error, sticky_err}); else n_pass++;
    step();
  endtask

  task automatic test_wait_error();
    load_addr(32'h0000_0040);
    HRDATA = 32'hFFFF_FFFF;
    send(1'b1, 32'h0, 2'b10, 1'b0, 1'b1);
    HREADY = 1'b0;
    step();
    n_chk++; if (HTRANS !== 2'b10 || HADDR !== 32'h40)
      $display("FAIL aph_wait got %b/%h want 10/00000040", HTRANS, HADDR); else n_pass++;
    HREADY = 1'b1;
    step();
    HREADY = 1'b0;
    step(); step();
    n_chk++; if ({HTRANS, rsp_valid, req_ready} !== 4'b0000)
      $display("FAIL dph_wait got %b want 0000", {HTRANS, rsp_valid, req_ready}); else n_pass++;
    step();
    HRESP = 1'b1;
    step();
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL err_cyc1 got %b want 0", rsp_valid); else n_pass++;
    HREADY = 1'b1;
    step();
    HRESP = 1'b0;
    n_chk++; if ({rsp_valid, rsp_error, sticky_err} !== 3'b111 || rsp_data !== 32'h0)
      $display("FAIL hresp_rsp got %b/%h want 111/00000000", {rsp_valid, rsp_error, sticky_err}, rsp_data); else n_pass++;
    n_chk++; if (cur_addr !== 32'h0000_0040) $display("FAIL hresp_noinc got %h want 00000040", cur_addr); else n_pass++;
    step();
    n_chk++; if ({rsp_valid, rsp_error} !== 2'b01) $display("FAIL rsp_hold got %b want 01", {rsp_valid, rsp_error}); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_wrap_reset();
    int seen;
    load_addr(32'hFFFF_FFFC);
    send(1'b1, 32'h0BAD_F00D, 2'b10, 1'b1, 1'b1);
    step(); step();
    n_chk++; if (rsp_error !== 1'b0 || cur_addr !== 32'h0)
      $display("FAIL wrap got %b/%h want 0/00000000", rsp_error, cur_addr); else n_pass++;
    step();
    send(1'b1, 32'h0000_ABCD, 2'b01, 1'b1, 1'b0);
    HREADY = 1'b0;
    n_chk++; if (HSIZE !== 3'b001) $display("FAIL hw_hsize got %b want 001", HSIZE); else n_pass++;
    HREADY = 1'b1;
    step();
    HREADY = 1'b0;
    step();
    n_chk++; if (HWDATA !== 32'hABCD_ABCD) $display("FAIL hw_hold got %h want abcdabcd", HWDATA); else n_pass++;
    #2 nRST = 1'b0;
    #1;
    n_chk++; if ({HTRANS, rsp_valid, req_ready} !== 4'b0001)
      $display("FAIL midrst got %b want 0001", {HTRANS, rsp_valid, req_ready}); else n_pass++;
    @(negedge CLK);
    nRST = 1'b1;
    HREADY = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL midrst_rsp got %0d want 0", seen); else n_pass++;
  endtask

`ifdef JTAG_AP_TIMEOUT_EN
  task automatic test_timeout();
    load_addr(32'h0);
    send(1'b1, 32'h0, 2'b10, 1'b0, 1'b0);
    HREADY = 1'b0;
    repeat (7) step();
    n_chk++; if (rsp_valid !== 1'b0 || HTRANS !== 2'b10)
      $display("FAIL to_early got %b/%b want 0/10", rsp_valid, HTRANS); else n_pass++;
    step();
    n_chk++; if ({rsp_valid, rsp_error, ap_timeout, HTRANS} !== 5'b11100)
      $display("FAIL to_fire got %b want 11100", {rsp_valid, rsp_error, ap_timeout, HTRANS}); else n_pass++;
    HREADY = 1'b1;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_chk++; if ({ap_timeout, sticky_err} !== 2'b00)
      $display("FAIL to_clr got %b want 00", {ap_timeout, sticky_err}); else n_pass++;
  endtask
`endif

  initial begin
    req_valid = 1'b0; req_data = 32'h0; req_regselect = 1'b0; req_size = 2'b00;
    req_addrinc = 1'b0; req_rw = 1'b0; err_clr = 1'b0;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    test_reset();
    test_word_write();
    test_reads();
    test_misalign();
    test_wait_error();
    test_wrap_reset();
`ifdef JTAG_AP_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
